// File: rtl/flip_select_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flip_select_ctrl                                           |
// | Description : WalkSAT flip-variable selector. Scans up to NCAND          |
// |               candidate slots of an unsatisfied clause, queries an       |
// |               external break-value counter for each valid slot and       |
// |               reports the minimum-break candidate. Latency is fixed at   |
// |               NCAND+2 cycles from start to done regardless of the mask.  |
// |               Optional macro WSAT_RANDOM_WALK_EN adds an LFSR-driven     |
// |               noise pick with a zero-break (freebie) override.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module flip_select_ctrl #(
  parameter int          NCAND     = 4,
  parameter int          VAR_W     = 5,
  parameter logic [7:0]  NOISE_TH  = 8'd64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NCAND-1:0]       cand_mask,
  input  logic [NCAND*VAR_W-1:0] cand_var,
  output logic                   cnt_req,
  output logic [VAR_W-1:0]       cnt_var,
  input  logic [4:0]             cnt_count,
  output logic                   busy,
  output logic                   done,
  output logic [VAR_W-1:0]       flip_var,
  output logic [4:0]             flip_brk,
  output logic                   zero_brk,
  output logic                   none_valid
);

  localparam int                SLOT_W    = (NCAND > 1) ? $clog2(NCAND) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCAND - 1);
  localparam logic [4:0]        MIN_INIT  = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [NCAND-1:0]         mask_q, mask_d;
  logic [NCAND*VAR_W-1:0]   vars_q, vars_d;
  logic [4:0]               min_q, min_d;
  logic [SLOT_W-1:0]        best_q, best_d;
  logic                     pend_q, pend_d;
  logic [SLOT_W-1:0]        pend_slot_q, pend_slot_d;
  logic [VAR_W-1:0]         flip_var_q, flip_var_d;
  logic [4:0]               flip_brk_q, flip_brk_d;
  logic                     zero_brk_q, zero_brk_d;
  logic                     none_valid_q, none_valid_d;

  logic [VAR_W-1:0]         var_arr [NCAND];
  logic                     take;
  logic [4:0]               min_cmp;
  logic [SLOT_W-1:0]        best_cmp;
  logic [SLOT_W-1:0]        sel_slot;
  logic [4:0]               sel_cnt;

  // Unpack the latched candidate variables into a slot-indexed array
  always_comb begin
    for (int i = 0; i < NCAND; i++) begin
      var_arr[i] = vars_q[i*VAR_W +: VAR_W];
    end
  end

  // Counter request and status outputs, all decoded from registered state
  always_comb begin
    cnt_req    = (state_q == SCAN) && mask_q[slot_q];
    cnt_var    = cnt_req ? var_arr[slot_q] : '0;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    flip_var   = flip_var_q;
    flip_brk   = flip_brk_q;
    zero_brk   = zero_brk_q;
    none_valid = none_valid_q;
  end

  // Running-minimum compare on the count returned for last cycle's request;
  // strictly-less keeps the lowest slot on ties
  always_comb begin
    take     = pend_q && (cnt_count < min_q);
    min_cmp  = take ? cnt_count : min_q;
    best_cmp = take ? pend_slot_q : best_q;
  end

`ifdef WSAT_RANDOM_WALK_EN
  logic [15:0]       lfsr_q, lfsr_d;
  logic [4:0]        cnt_arr_q [NCAND];
  logic [4:0]        cnt_arr_d [NCAND];
  logic [SLOT_W-1:0] noise_slot;
  logic [SLOT_W-1:0] probe;
  logic              noise_hit;

  // LFSR advances once per accepted start; per-slot counts are kept so the
  // noise pick can report its own break value
  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_q == IDLE) && start) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    cnt_arr_d = cnt_arr_q;
    if (pend_q) begin
      cnt_arr_d[pend_slot_q] = cnt_count;
    end
  end

  // Final pick: the noise decision uses the LFSR value produced by this
  // operation's start; any zero-break candidate forces the greedy choice
  always_comb begin
    noise_slot = '0;
    noise_hit  = 1'b0;
    probe      = '0;
    for (int k = 0; k < NCAND; k++) begin
      probe = SLOT_W'((int'(lfsr_q[9:8]) + k) % NCAND);
      if (!noise_hit && mask_q[probe]) begin
        noise_slot = probe;
        noise_hit  = 1'b1;
      end
    end
    sel_slot = best_cmp;
    sel_cnt  = min_cmp;
    if (noise_hit && (lfsr_q[7:0] < NOISE_TH) && (min_cmp != 5'd0)) begin
      sel_slot = noise_slot;
      sel_cnt  = cnt_arr_d[noise_slot];
    end
  end

  // LFSR and per-slot count storage
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      for (int i = 0; i < NCAND; i++) begin
        cnt_arr_q[i] <= 5'd0;
      end
    end else begin
      lfsr_q    <= lfsr_d;
      cnt_arr_q <= cnt_arr_d;
    end
  end
`else
  logic unused_cfg;

  // Pure greedy build: the random-walk parameters are intentionally inert
  always_comb begin
    unused_cfg = ^{NOISE_TH, LFSR_SEED};
    sel_slot   = best_cmp;
    sel_cnt    = min_cmp;
  end
`endif

  // Next-state and datapath updates for the IDLE/SCAN/DRAIN/DONE sequence
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    mask_d       = mask_q;
    vars_d       = vars_q;
    min_d        = min_cmp;
    best_d       = best_cmp;
    pend_d       = 1'b0;
    pend_slot_d  = slot_q;
    flip_var_d   = flip_var_q;
    flip_brk_d   = flip_brk_q;
    zero_brk_d   = zero_brk_q;
    none_valid_d = none_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = cand_mask;
          vars_d  = cand_var;
          min_d   = MIN_INIT;
          best_d  = '0;
          slot_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        pend_d = cnt_req;
        if (slot_q == LAST_SLOT) begin
          state_d = DRAIN;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      DRAIN: begin
        // Last compare lands here, so results are captured on entry to DONE
        state_d      = DONE;
        none_valid_d = (mask_q == '0);
        if (mask_q == '0) begin
          flip_var_d = '0;
          flip_brk_d = 5'd0;
          zero_brk_d = 1'b0;
        end else begin
          flip_var_d = var_arr[sel_slot];
          flip_brk_d = sel_cnt;
          zero_brk_d = (sel_cnt == 5'd0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      mask_q       <= '0;
      vars_q       <= '0;
      min_q        <= MIN_INIT;
      best_q       <= '0;
      pend_q       <= 1'b0;
      pend_slot_q  <= '0;
      flip_var_q   <= '0;
      flip_brk_q   <= 5'd0;
      zero_brk_q   <= 1'b0;
      none_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      mask_q       <= mask_d;
      vars_q       <= vars_d;
      min_q        <= min_d;
      best_q       <= best_d;
      pend_q       <= pend_d;
      pend_slot_q  <= pend_slot_d;
      flip_var_q   <= flip_var_d;
      flip_brk_q   <= flip_brk_d;
      zero_brk_q   <= zero_brk_d;
      none_valid_q <= none_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flip_select_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_flip_select_ctrl                                        |
// | Description : Directed self-checking bench for flip_select_ctrl with a   |
// |               break-count responder and an expected-result queue.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_flip_select_ctrl;

  localparam int NCAND = 4;
  localparam int VAR_W = 5;
`ifdef WSAT_RANDOM_WALK_EN
  localparam bit         RW_EN       = 1'b1;
  localparam logic [7:0] TB_NOISE_TH = 8'd255;
`else
  localparam bit         RW_EN       = 1'b0;
  localparam logic [7:0] TB_NOISE_TH = 8'd64;
`endif
  localparam logic [15:0] TB_SEED = 16'hACE1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [NCAND-1:0]       cand_mask;
  logic [NCAND*VAR_W-1:0] cand_var;
  logic                   cnt_req;
  logic [VAR_W-1:0]       cnt_var;
  logic [4:0]             cnt_count = 5'd0;
  logic                   busy, done;
  logic [VAR_W-1:0]       flip_var;
  logic [4:0]             flip_brk;
  logic                   zero_brk, none_valid;

  typedef struct packed {
    logic [4:0] fv;
    logic [4:0] fb;
    logic       z;
    logic       nv;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  cnt_tab [32];
  int          req_cnt  = 0;
  logic [31:0] req_vars = '0;
  logic [15:0] lfsr_m;

  flip_select_ctrl #(
    .NCAND     (NCAND),
    .VAR_W     (VAR_W),
    .NOISE_TH  (TB_NOISE_TH),
    .LFSR_SEED (TB_SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cand_mask  (cand_mask),
    .cand_var   (cand_var),
    .cnt_req    (cnt_req),
    .cnt_var    (cnt_var),
    .cnt_count  (cnt_count),
    .busy       (busy),
    .done       (done),
    .flip_var   (flip_var),
    .flip_brk   (flip_brk),
    .zero_brk   (zero_brk),
    .none_valid (none_valid)
  );

  always #5 clk = ~clk;

  // Break-value counter: answers one cycle after a request, 0 otherwise
  always @(posedge clk) begin
    cnt_count <= cnt_req ? cnt_tab[cnt_var] : 5'd0;
    if (cnt_req) begin
      req_cnt++;
      req_vars[cnt_var] = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Reference selection: greedy strict minimum, optional noise pick
  function automatic exp_t model(input logic [3:0] m, input logic [19:0] v,
                                 input logic [19:0] c, input logic [15:0] lf);
    exp_t       e;
    int         best;
    logic [4:0] mn;
    bit         zero_any;
    bit         hit;
    logic [1:0] idx;
    e = '0;
    if (m == 4'b0000) begin
      e.nv = 1'b1;
      return e;
    end
    best = 0; mn = 5'd31; zero_any = 1'b0;
    for (int i = 0; i < NCAND; i++) begin
      if (m[i]) begin
        if (c[i*5 +: 5] < mn) begin
          mn = c[i*5 +: 5];
          best = i;
        end
        if (c[i*5 +: 5] == 5'd0) zero_any = 1'b1;
      end
    end
    if (RW_EN && (lf[7:0] < TB_NOISE_TH) && !zero_any) begin
      hit = 1'b0;
      for (int k = 0; k < NCAND; k++) begin
        idx = 2'((int'(lf[9:8]) + k) % NCAND);
        if (!hit && m[idx]) begin
          best = int'(idx);
          hit = 1'b1;
        end
      end
    end
    e.fv = v[best*5 +: 5];
    e.fb = c[best*5 +: 5];
    e.z  = (e.fb == 5'd0);
    return e;
  endfunction

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"},       busy,       0);
    check({nm, "_done"},       done,       0);
    check({nm, "_cnt_req"},    cnt_req,    0);
    check({nm, "_cnt_var"},    cnt_var,    0);
    check({nm, "_flip_var"},   flip_var,   0);
    check({nm, "_flip_brk"},   flip_brk,   0);
    check({nm, "_zero_brk"},   zero_brk,   0);
    check({nm, "_none_valid"}, none_valid, 0);
  endtask

  // One operation: restart_at / rst_at give the cycle (1 = first SCAN cycle)
  // at which an extra start or a reset is driven; 0 disables each
  task automatic run_op(input string nm, input logic [3:0] m, input logic [19:0] v,
                        input logic [19:0] c, input int restart_at, input int rst_at);
    exp_t        e;
    int          lat;
    bit          got;
    bit          seen_done;
    logic [31:0] exp_vars;
    int          exp_req;
    exp_vars = '0; exp_req = 0;
    for (int i = 0; i < NCAND; i++) begin
      cnt_tab[v[i*5 +: 5]] = c[i*5 +: 5];
      if (m[i]) begin
        exp_vars[v[i*5 +: 5]] = 1'b1;
        exp_req++;
      end
    end
    lfsr_m = lfsr_next(lfsr_m);
    if (rst_at == 0) sb.push_back(model(m, v, c, lfsr_m));
    @(negedge clk);
    req_cnt = 0; req_vars = '0;
    cand_mask = m; cand_var = v; start = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      start = 1'b0; cand_mask = ~m; cand_var = ~v;
      if (lat == 1) check({nm, "_busy_first"}, busy, 1);
      if (lat == restart_at) start = 1'b1;
      if (rst_at != 0 && lat == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lfsr_m = TB_SEED;
        check_reset_outputs({nm, "_after_rst"});
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (done) seen_done = 1'b1;
        end
        check({nm, "_no_done"}, seen_done, 0);
        return;
      end
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    check({nm, "_done_seen"}, got, 1);
    if (got) begin
      check({nm, "_latency"},    lat,        NCAND + 2);
      check({nm, "_busy_done"},  busy,       1);
      check({nm, "_flip_var"},   flip_var,   e.fv);
      check({nm, "_flip_brk"},   flip_brk,   e.fb);
      check({nm, "_zero_brk"},   zero_brk,   e.z);
      check({nm, "_none_valid"}, none_valid, e.nv);
      check({nm, "_req_cnt"},    req_cnt,    exp_req);
      check({nm, "_req_vars"},   req_vars,   exp_vars);
      @(negedge clk);
      check({nm, "_done_pulse"}, done,       0);
      check({nm, "_idle_busy"},  busy,       0);
      check({nm, "_held_var"},   flip_var,   e.fv);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cand_mask = '0; cand_var = '0;
    lfsr_m = TB_SEED;
    for (int i = 0; i < 32; i++) cnt_tab[i] = 5'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Vectors packed as {slot3, slot2, slot1, slot0}
    run_op("all_valid",  4'b1111, {5'd25, 5'd17, 5'd12, 5'd3},  {5'd9,  5'd3, 5'd3, 5'd7},  0, 0);
    run_op("sparse",     4'b0101, {5'd30, 5'd21, 5'd6,  5'd14}, {5'd2,  5'd0, 5'd1, 5'd4},  0, 0);
    run_op("empty",      4'b0000, {5'd1,  5'd2,  5'd4,  5'd8},  {5'd1,  5'd1, 5'd1, 5'd1},  0, 0);
    run_op("tie_masked", 4'b1110, {5'd11, 5'd19, 5'd27, 5'd5},  {5'd5,  5'd5, 5'd5, 5'd0},  0, 0);
    run_op("single_max", 4'b1000, {5'd29, 5'd7,  5'd9,  5'd13}, {5'd20, 5'd0, 5'd0, 5'd0},  0, 0);
    run_op("rw_nozero",  4'b1111, {5'd24, 5'd16, 5'd8,  5'd2},  {5'd8,  5'd6, 5'd2, 5'd5},  0, 0);
    run_op("rw_freebie", 4'b1111, {5'd23, 5'd15, 5'd10, 5'd1},  {5'd8,  5'd6, 5'd0, 5'd5},  0, 0);
    run_op("restart",    4'b1111, {5'd26, 5'd18, 5'd20, 5'd4},  {5'd12, 5'd11, 5'd4, 5'd10}, 2, 0);
    run_op("rst_drain",  4'b1011, {5'd22, 5'd28, 5'd31, 5'd0},  {5'd2,  5'd9, 5'd1, 5'd3},  0, 5);
    run_op("post_rst",   4'b0110, {5'd17, 5'd9,  5'd13, 5'd21}, {5'd3,  5'd1, 5'd6, 5'd9},  0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
